// File: rtl/neureka_streamout_packer_pkg.sv
// Shared types and constants for the NEUREKA streamout packer and its byte-mask helper.
package neureka_streamout_packer_pkg;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH    = 256;
    localparam int unsigned NEUREKA_PE_H_DEFAULT     = 6;
    localparam int unsigned NEUREKA_PE_W_DEFAULT     = 6;
    localparam int unsigned NEUREKA_NR_PE            = NEUREKA_PE_H_DEFAULT * NEUREKA_PE_W_DEFAULT;
    localparam int unsigned NEUREKA_PACKER_BEATS_32B = 4;
    localparam int unsigned NEUREKA_PACKER_PE_W      = $clog2(NEUREKA_NR_PE + 1);
    localparam int unsigned NEUREKA_PACKER_BEAT_W    = $clog2(NEUREKA_PACKER_BEATS_32B);
    localparam int unsigned NEUREKA_KOUT_REM_W       = 6;

    typedef struct packed {
        logic                              start;
        logic [NEUREKA_PACKER_PE_W-1:0]    nb_pe;
        logic [NEUREKA_KOUT_REM_W-1:0]     kout_rem;
        logic                              mode32;
    } ctrl_packer_t;

    typedef struct packed {
        logic                              busy;
        logic                              done;
        logic [NEUREKA_PACKER_PE_W-1:0]    pe_idx;
        logic [NEUREKA_PACKER_BEAT_W-1:0]  beat_idx;
    } flags_packer_t;

    typedef struct packed {
        logic          busy;
        logic          done;
        flags_packer_t packer;
    } flags_engine_t;

    typedef enum logic [1:0] {
        PACKER_IDLE = 2'd0,
        PACKER_RUN  = 2'd1,
        PACKER_DONE = 2'd2
    } packer_state_e;

endpackage

// File: rtl/neureka_stream_intf.sv
// Valid/ready byte-strobed stream used on both sides of the packer.
interface neureka_stream_intf #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport sink   (input  valid, data, strb, output ready);
    modport source (output valid, data, strb, input  ready);
endinterface

// File: rtl/neureka_streamout_mask.sv
// Combinational byte-valid mask for a beat, from output mode, channel remainder and beat index.
module neureka_streamout_mask
    import neureka_streamout_packer_pkg::*;
#(
    parameter int unsigned NB_BYTES = NEUREKA_MEM_BANDWIDTH / 8,
    parameter int unsigned BEAT_W   = NEUREKA_PACKER_BEAT_W
) (
    input  logic                          mode32,
    input  logic [NEUREKA_KOUT_REM_W-1:0] kout_rem,
    input  logic [BEAT_W-1:0]             beat_idx,
    output logic [NB_BYTES-1:0]           mask_c
);

    logic [7:0] kc;
    logic [7:0] off;
    logic [7:0] rem;
    logic [7:0] vc;
    logic [7:0] nbytes;

    // In 32-bit mode each beat carries 8 channels of 4 bytes; kout_rem==0 means a full 32.
    always_comb begin
        kc     = (kout_rem == '0) ? 8'd32 : 8'(kout_rem);
        off    = 8'(beat_idx) << 3;
        rem    = (kc > off) ? (kc - off) : 8'd0;
        vc     = (rem > 8'd8) ? 8'd8 : rem;
        nbytes = mode32 ? (vc << 2) : kc;
        mask_c = '0;
        for (int j = 0; j < int'(NB_BYTES); j++) begin
            mask_c[j] = (8'(j) < nbytes);
        end
    end

endmodule

// File: rtl/neureka_streamout_packer.sv
// Counts PE output beats per tile, applies the kout remainder byte mask and registers the result.
// Optional: NEUREKA_PACKER_DROP_EMPTY_EN drops all-zero-mask beats in 32-bit mode.
module neureka_streamout_packer
    import neureka_streamout_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NEUREKA_MEM_BANDWIDTH,
    parameter int unsigned NR_PE      = NEUREKA_NR_PE,
    parameter int unsigned BEATS_32B  = NEUREKA_PACKER_BEATS_32B
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  ctrl_packer_t              ctrl_i,
    neureka_stream_intf.sink          push_i,
    neureka_stream_intf.source        pop_o,
    output flags_packer_t             flags_o
);

    localparam int unsigned NB_BYTES = DATA_WIDTH / 8;
    localparam int unsigned PE_W     = $clog2(NR_PE + 1);
    localparam int unsigned BEAT_W   = $clog2(BEATS_32B);

    packer_state_e                 state;
    logic [PE_W-1:0]               cfg_nb_pe;
    logic [NEUREKA_KOUT_REM_W-1:0] cfg_kout_rem;
    logic                          cfg_mode32;
    logic [PE_W-1:0]               pe_idx;
    logic [BEAT_W-1:0]             beat_idx;
    logic                          busy_q;
    logic                          done_q;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [NB_BYTES-1:0]           out_strb;

    logic [NB_BYTES-1:0]           mask;
    logic [NB_BYTES-1:0]           strb_m;
    logic [DATA_WIDTH-1:0]         data_m;
    logic                          accept;
    logic                          drop;
    logic                          last_beat;
    logic                          last_pe;

    neureka_streamout_mask #(
        .NB_BYTES (NB_BYTES),
        .BEAT_W   (BEAT_W)
    ) i_mask (
        .mode32   (cfg_mode32),
        .kout_rem (cfg_kout_rem),
        .beat_idx (beat_idx),
        .mask_c   (mask)
    );

    // enable_i also gates acceptance so a frozen packer never swallows a beat.
    assign push_i.ready = enable_i & (state == PACKER_RUN) & (~out_valid | pop_o.ready);
    assign accept       = push_i.valid & push_i.ready;
    assign last_beat    = cfg_mode32 ? (beat_idx == BEAT_W'(BEATS_32B - 1)) : 1'b1;
    assign last_pe      = (pe_idx == cfg_nb_pe - PE_W'(1));

`ifdef NEUREKA_PACKER_DROP_EMPTY_EN
    assign drop = cfg_mode32 & ~|mask;
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        strb_m = push_i.strb & mask;
        data_m = '0;
        for (int j = 0; j < int'(NB_BYTES); j++) begin
            data_m[8*j +: 8] = strb_m[j] ? push_i.data[8*j +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= PACKER_IDLE;
            cfg_nb_pe    <= '0;
            cfg_kout_rem <= '0;
            cfg_mode32   <= 1'b0;
            pe_idx       <= '0;
            beat_idx     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_strb     <= '0;
        end else if (clear_i) begin
            state        <= PACKER_IDLE;
            cfg_nb_pe    <= '0;
            cfg_kout_rem <= '0;
            cfg_mode32   <= 1'b0;
            pe_idx       <= '0;
            beat_idx     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_strb     <= '0;
        end else if (enable_i) begin
            done_q <= 1'b0;

            // A new beat overwrites the register in the same cycle the old one is popped.
            if (accept && !drop) begin
                out_valid <= 1'b1;
                out_data  <= data_m;
                out_strb  <= strb_m;
            end else if (out_valid && pop_o.ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                PACKER_IDLE: begin
                    if (ctrl_i.start) begin
                        cfg_nb_pe    <= PE_W'(ctrl_i.nb_pe);
                        cfg_kout_rem <= ctrl_i.kout_rem;
                        cfg_mode32   <= ctrl_i.mode32;
                        pe_idx       <= '0;
                        beat_idx     <= '0;
                        busy_q       <= 1'b1;
                        state        <= (ctrl_i.nb_pe == '0) ? PACKER_DONE : PACKER_RUN;
                    end
                end
                PACKER_RUN: begin
                    if (accept) begin
                        if (last_beat && last_pe) begin
                            pe_idx   <= '0;
                            beat_idx <= '0;
                            state    <= PACKER_DONE;
                        end else if (last_beat) begin
                            beat_idx <= '0;
                            pe_idx   <= pe_idx + PE_W'(1);
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                        end
                    end
                end
                PACKER_DONE: begin
                    if (!out_valid) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= PACKER_IDLE;
                    end
                end
                default: state <= PACKER_IDLE;
            endcase
        end
    end

    assign pop_o.valid = out_valid;
    assign pop_o.data  = out_data;
    assign pop_o.strb  = out_strb;

    always_comb begin
        flags_o          = '0;
        flags_o.busy     = busy_q;
        flags_o.done     = done_q;
        flags_o.pe_idx   = NEUREKA_PACKER_PE_W'(pe_idx);
        flags_o.beat_idx = NEUREKA_PACKER_BEAT_W'(beat_idx);
    end

endmodule

// File: tb/tb_neureka_streamout_packer.sv
// Directed self-checking bench for neureka_streamout_packer (honours NEUREKA_PACKER_DROP_EMPTY_EN).
module tb_neureka_streamout_packer;
    import neureka_streamout_packer_pkg::*;

    localparam int unsigned DW = 256;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          enable;
    ctrl_packer_t  ctrl;
    flags_packer_t flags;

    neureka_stream_intf #(.DATA_WIDTH(DW)) push ();
    neureka_stream_intf #(.DATA_WIDTH(DW)) pop ();

    int checks = 0;
    int errors = 0;

    neureka_streamout_packer #(
        .DATA_WIDTH (DW),
        .NR_PE      (NEUREKA_NR_PE),
        .BEATS_32B  (NEUREKA_PACKER_BEATS_32B)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .enable_i (enable),
        .ctrl_i   (ctrl),
        .push_i   (push),
        .pop_o    (pop),
        .flags_o  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte j of beat b carries channel 8*b + j/4 in 32-bit mode, channel j in 8-bit mode.
    function automatic logic [31:0] model_mask(input int kout, input bit m32, input int b);
        logic [31:0] m;
        int c;
        c = (kout == 0) ? 32 : kout;
        m = '0;
        for (int j = 0; j < 32; j++) begin
            if (m32) m[j] = ((8 * b + j / 4) < c);
            else     m[j] = (j < c);
        end
        return m;
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom();
        return d;
    endfunction

    task automatic run_tile(input string name, input int nb, input int kout, input bit m32,
                            input bit rnd, input int exp_out,
                            output logic [3:0][31:0] strbs, output int pop_to_done);
        logic [255:0] q_data[$];
        logic [31:0]  q_strb[$];
        logic [255:0] held_data;
        logic [255:0] exp_d;
        logic [31:0]  m;
        logic [31:0]  exp_s;
        int bpp, total, n_in, n_out, cyc, dones, last_pop, done_cyc;
        bit held, push_fire, pop_fire, keep;
        bpp = m32 ? 4 : 1;
        total = nb * bpp;
        n_in = 0; n_out = 0; cyc = 0; dones = 0; last_pop = 0; done_cyc = 0;
        held = 0; push_fire = 0; pop_fire = 0;
        held_data = '0;
        strbs = '0;
        @(negedge clk);
        ctrl.start    = 1'b1;
        ctrl.nb_pe    = NEUREKA_PACKER_PE_W'(nb);
        ctrl.kout_rem = 6'(kout);
        ctrl.mode32   = m32;
        while (dones == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ctrl.start = 1'b0;
            if (held) begin
                check({name, "_stall_valid"}, 256'(pop.valid), 256'(1));
                check({name, "_stall_data"}, pop.data, held_data);
            end
            if (push_fire) push.valid = 1'b0;
            pop.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!push.valid && n_in < total) begin
                push.valid = 1'b1;
                push.data  = rand_data();
                if (rnd) push.strb = $urandom();
                else     push.strb = '1;
            end
            #1;
            if (flags.done) begin
                dones++;
                done_cyc = cyc;
            end
            push_fire = push.valid && push.ready;
            pop_fire  = pop.valid && pop.ready;
            if (pop_fire) begin
                check({name, "_pop_has_expected"}, 256'(q_data.size() > 0), 256'(1));
                if (q_data.size() > 0) begin
                    check({name, "_pop_strb"}, 256'(pop.strb), 256'(q_strb.pop_front()));
                    check({name, "_pop_data"}, pop.data, q_data.pop_front());
                end
                if (n_out < 4) strbs[n_out] = pop.strb;
                n_out++;
                last_pop = cyc;
            end
            held      = pop.valid && !pop.ready;
            held_data = pop.data;
            if (push_fire) begin
                m     = model_mask(kout, m32, n_in % bpp);
                exp_s = push.strb & m;
                for (int j = 0; j < 32; j++) exp_d[8*j +: 8] = exp_s[j] ? push.data[8*j +: 8] : 8'h00;
                keep = 1'b1;
`ifdef NEUREKA_PACKER_DROP_EMPTY_EN
                if (m32 && m == '0) keep = 1'b0;
`endif
                if (keep) begin
                    q_data.push_back(exp_d);
                    q_strb.push_back(exp_s);
                end
                n_in++;
            end
        end
        push.valid = 1'b0;
        pop.ready  = 1'b1;
        check({name, "_done_seen"}, 256'(dones), 256'(1));
        check({name, "_beats_in"}, 256'(n_in), 256'(total));
        check({name, "_beats_out"}, 256'(n_out), 256'(exp_out));
        check({name, "_leftover"}, 256'(q_data.size()), 256'(0));
        @(negedge clk);
        #1;
        check({name, "_done_one_cycle"}, 256'(flags.done), 256'(0));
        check({name, "_busy_after"}, 256'(flags.busy), 256'(0));
        pop_to_done = done_cyc - last_pop;
    endtask

    initial begin
        logic [3:0][31:0] s;
        int p2d;
        int acc;
        bit saw_done;

        rst = 1'b1; clear = 1'b0; enable = 1'b1; ctrl = '0;
        push.valid = 1'b0; push.data = '0; push.strb = '0; pop.ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", 256'(pop.valid), 256'(0));
        check("reset_strb", 256'(pop.strb), 256'(0));
        check("reset_flags", 256'(flags), 256'(0));
        check("reset_ready", 256'(push.ready), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // 8-bit, full channels
        run_tile("t1", 9, 0, 1'b0, 1'b0, 9, s, p2d);
        check("t1_strb0", 256'(s[0]), 256'(32'hFFFF_FFFF));
        check("t1_strb3", 256'(s[3]), 256'(32'hFFFF_FFFF));
        check("t1_pop_to_done", 256'(p2d), 256'(2));

        // 8-bit, 5 channels
        run_tile("t2", 2, 5, 1'b0, 1'b0, 2, s, p2d);
        check("t2_strb0", 256'(s[0]), 256'(32'h0000_001F));
        check("t2_strb1", 256'(s[1]), 256'(32'h0000_001F));

        // 32-bit, 12 channels
`ifdef NEUREKA_PACKER_DROP_EMPTY_EN
        run_tile("t3", 1, 12, 1'b1, 1'b0, 2, s, p2d);
        check("t3_strb0", 256'(s[0]), 256'(32'hFFFF_FFFF));
        check("t3_strb1", 256'(s[1]), 256'(32'h0000_FFFF));
`else
        run_tile("t3", 1, 12, 1'b1, 1'b0, 4, s, p2d);
        check("t3_strb0", 256'(s[0]), 256'(32'hFFFF_FFFF));
        check("t3_strb1", 256'(s[1]), 256'(32'h0000_FFFF));
        check("t3_strb2", 256'(s[2]), 256'(32'h0000_0000));
        check("t3_strb3", 256'(s[3]), 256'(32'h0000_0000));
`endif

        // backpressure, random strobes
        run_tile("t4", 36, 20, 1'b0, 1'b1, 36, s, p2d);
`ifdef NEUREKA_PACKER_DROP_EMPTY_EN
        run_tile("t5", 3, 20, 1'b1, 1'b1, 9, s, p2d);
`else
        run_tile("t5", 3, 20, 1'b1, 1'b1, 12, s, p2d);
`endif

        // soft clear after the third beat
        @(negedge clk);
        ctrl.start = 1'b1; ctrl.nb_pe = NEUREKA_PACKER_PE_W'(9); ctrl.kout_rem = '0; ctrl.mode32 = 1'b0;
        pop.ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            @(negedge clk);
            ctrl.start = 1'b0;
            push.valid = 1'b1;
            push.data  = rand_data();
            push.strb  = '1;
            #1;
            if (push.ready) acc++;
        end
        check("clr_accepted", 256'(acc), 256'(3));
        @(negedge clk);
        push.valid = 1'b0;
        clear = 1'b1;
        #1;
        check("clr_pre_valid", 256'(pop.valid), 256'(1));
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_valid", 256'(pop.valid), 256'(0));
        check("clr_busy", 256'(flags.busy), 256'(0));
        check("clr_ready", 256'(push.ready), 256'(0));
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            saw_done = saw_done | flags.done;
        end
        check("clr_no_done", 256'(saw_done), 256'(0));
        run_tile("t6", 1, 0, 1'b0, 1'b0, 1, s, p2d);

        // empty tile
        @(negedge clk);
        ctrl.start = 1'b1; ctrl.nb_pe = '0; ctrl.kout_rem = '0; ctrl.mode32 = 1'b0;
        push.valid = 1'b1;
        #1;
        check("zero_ready_idle", 256'(push.ready), 256'(0));
        @(negedge clk);
        ctrl.start = 1'b0;
        #1;
        check("zero_ready_done", 256'(push.ready), 256'(0));
        check("zero_busy", 256'(flags.busy), 256'(1));
        @(negedge clk);
        #1;
        check("zero_done", 256'(flags.done), 256'(1));
        @(negedge clk);
        #1;
        check("zero_done_pulse", 256'(flags.done), 256'(0));
        push.valid = 1'b0;

        // async reset mid-tile
        @(negedge clk);
        ctrl.start = 1'b1; ctrl.nb_pe = NEUREKA_PACKER_PE_W'(9); ctrl.kout_rem = 6'd3; ctrl.mode32 = 1'b0;
        pop.ready = 1'b0;
        @(negedge clk);
        ctrl.start = 1'b0;
        push.valid = 1'b1;
        push.data  = rand_data();
        push.strb  = '1;
        @(negedge clk);
        push.valid = 1'b0;
        #1;
        check("rst_pre_valid", 256'(pop.valid), 256'(1));
        check("rst_pre_pe_idx", 256'(flags.pe_idx), 256'(1));
        check("rst_pre_strb", 256'(pop.strb), 256'(32'h0000_0007));
        rst = 1'b1;
        #1;
        check("rst_valid", 256'(pop.valid), 256'(0));
        check("rst_data", pop.data, 256'(0));
        check("rst_strb", 256'(pop.strb), 256'(0));
        check("rst_flags", 256'(flags), 256'(0));
        check("rst_ready", 256'(push.ready), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        pop.ready = 1'b1;
        run_tile("t7", 2, 0, 1'b1, 1'b0, 8, s, p2d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
